// File: rtl/conversor_preco_bcd.sv
// Rounds a price product (1/1000 cent units) to whole cents and converts
// it to packed BCD for the price display, using a start/busy/done handshake.
//
// Ports:
//   clk, rst_n  rising-edge clock, async active-low reset
//   start       request a conversion (sampled only while idle)
//   preco       product in 1/1000 cent, latched when start is accepted
//   busy        conversion in progress
//   done        one-cycle pulse, bcd/overflow just updated
//   bcd         packed BCD cents, digit 0 in [3:0], holds last result
//   overflow    last result above 10^DIGITS-1, holds with bcd
module conversor_preco_bcd #(
  parameter int IN_W   = 29,
  parameter int Q_W    = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       preco,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int REM_W = 10;
  localparam int BCD_W = 4 * DIGITS;
  localparam int DD_W  = BCD_W + Q_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [REM_W:0]    DIVISOR = (REM_W+1)'(1000);
  localparam logic [REM_W-1:0]  HALF    = REM_W'(500);
  localparam logic [IN_W-1:0]   MAXV    = IN_W'(10**DIGITS - 1);
  localparam logic [CNT_W-1:0]  DIV_END = CNT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0]  BCD_END = CNT_W'(Q_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    ROUND,
    BCD,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // dvd_q holds the dividend and fills with quotient bits as it shifts,
  // so after IN_W steps it is the quotient.
  logic [IN_W-1:0]   dvd_q;
  logic [REM_W-1:0]  rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DD_W-1:0]   dd_q;
  logic              ovf_q;
  logic              done_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              overflow_q;

  logic [REM_W:0]    trial;
  logic [REM_W:0]    diff;
  logic              ge;
  logic [REM_W-1:0]  rem_d;
  logic [IN_W-1:0]   q_sum;
  logic [DD_W-1:0]   dd_adj;
  logic              last_div;
  logic              last_bcd;

  assign trial    = {rem_q, dvd_q[IN_W-1]};
  assign diff     = trial - DIVISOR;
  assign ge       = (trial >= DIVISOR);
  assign rem_d    = ge ? diff[REM_W-1:0] : trial[REM_W-1:0];
  assign q_sum    = dvd_q + IN_W'(rem_q >= HALF);
  assign last_div = (cnt_q == DIV_END);
  assign last_bcd = (cnt_q == BCD_END);

  // Add-3 correction on every BCD nibble that would exceed 9 once doubled.
  always_comb begin
    dd_adj = dd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dd_q[Q_W+4*i +: 4] >= 4'd5) begin
        dd_adj[Q_W+4*i +: 4] = dd_q[Q_W+4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = DIV;
      end
      DIV: begin
        if (last_div) state_d = ROUND;
      end
      ROUND: begin
        state_d = BCD;
      end
      BCD: begin
        if (last_bcd) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      dd_q       <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q <= preco;
            rem_q <= '0;
            cnt_q <= '0;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[IN_W-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
        end
        ROUND: begin
          // Compared at full width so quotient bits above Q_W count.
          ovf_q <= (q_sum > MAXV);
          dd_q  <= {{BCD_W{1'b0}}, q_sum[Q_W-1:0]};
          cnt_q <= '0;
        end
        BCD: begin
          dd_q  <= {dd_adj[DD_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          bcd_q      <= ovf_q ? {DIGITS{4'h9}} : dd_q[DD_W-1:Q_W];
          overflow_q <= ovf_q;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_conversor_preco_bcd.sv
// Self-checking bench for conversor_preco_bcd: vector table, random
// stimulus against an arithmetic reference, and handshake corner cases.
module tb_conversor_preco_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [28:0] preco;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  conversor_preco_bcd #(
    .IN_W(29),
    .Q_W(14),
    .DIGITS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .preco(preco),
    .busy(busy),
    .done(done),
    .bcd(bcd),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] p;
    logic [15:0] b;
    logic        o;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Round half up to cents, saturate to 9999 with overflow flag.
  function automatic void ref_model(input logic [28:0] p,
                                    output logic [15:0] eb,
                                    output logic eo);
    longint c;
    longint d;
    c  = (longint'(p) + 500) / 1000;
    eo = (c > 9999);
    eb = 16'h9999;
    if (!eo) begin
      d = 1;
      for (int i = 0; i < 4; i++) begin
        eb[4*i +: 4] = 4'((c / d) % 10);
        d = d * 10;
      end
    end
  endfunction

  task automatic run_conv(input logic [28:0] p, output int lat);
    @(negedge clk);
    preco = p;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    vec_t        tbl[10];
    int          lat;
    int          ndone;
    int          gap;
    logic [28:0] p;
    logic [15:0] eb;
    logic        eo;

    tbl[0] = '{29'd705000,    16'h0705, 1'b0};
    tbl[1] = '{29'd1499500,   16'h1500, 1'b0};
    tbl[2] = '{29'd1499499,   16'h1499, 1'b0};
    tbl[3] = '{29'd499,       16'h0000, 1'b0};
    tbl[4] = '{29'd500,       16'h0001, 1'b0};
    tbl[5] = '{29'd0,         16'h0000, 1'b0};
    tbl[6] = '{29'd9999499,   16'h9999, 1'b0};
    tbl[7] = '{29'd9999500,   16'h9999, 1'b1};
    tbl[8] = '{29'h1FFFFFFF,  16'h9999, 1'b1};
    tbl[9] = '{29'd4189185,   16'h4189, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    preco = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {16'd0, bcd}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_conv(tbl[i].p, lat);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd45);
      chk($sformatf("tbl%0d_bcd", i), {16'd0, bcd}, {16'd0, tbl[i].b});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].o});
    end

    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) p = 29'($urandom % 10_001_000);
      else            p = 29'($urandom);
      ref_model(p, eb, eo);
      run_conv(p, lat);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd45);
      chk($sformatf("rnd%0d_bcd", i), {16'd0, bcd}, {16'd0, eb});
      chk($sformatf("rnd%0d_ovf", i), {31'd0, overflow}, {31'd0, eo});
    end

    // Extra start pulses mid-conversion are ignored.
    run_conv(29'd4189185, lat);
    @(negedge clk);
    preco = 29'd705000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 5 || k == 20) begin
        start = 1'b1;
        preco = 29'd1499500;
      end else begin
        start = 1'b0;
      end
      if (k == 30) chk("ign_bcd_hold", {16'd0, bcd}, 32'h4189);
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
        chk("ign_busy_done", {31'd0, busy}, 32'd0);
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_lat", 32'(lat), 32'd45);
    chk("ign_bcd", {16'd0, bcd}, 32'h0705);

    // Reset mid-conversion aborts with no done.
    @(negedge clk);
    preco = 29'd1499500;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bcd", {16'd0, bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Start held high: back-to-back conversions every 46 cycles.
    @(negedge clk);
    preco = 29'd1000;
    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      gap = -1;
      for (int k = 1; k <= 200; k++) begin
        @(negedge clk);
        if (done) begin
          gap = k;
          break;
        end
      end
      chk($sformatf("b2b%0d_gap", r), 32'(gap), 32'd46);
      chk($sformatf("b2b%0d_bcd", r), {16'd0, bcd}, 32'(r + 1));
      chk($sformatf("b2b%0d_busy", r), {31'd0, busy}, 32'd0);
      preco = 29'((r + 2) * 1000);
      if (r == 2) start = 1'b0;
    end
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("b2b_stop", 32'(ndone), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
